// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sharing of one mod-MAX interval counter among
// NREQ requesters. The winner's terminal value is latched (clamped to MAX-1),
// the counter runs 0..len while grant is high, then a one-cycle done pulse is
// returned to the owner.
// Optional build macro COUNTER_ARBITER_ABORT_EN: when defined, the owner
// dropping req during COUNT aborts the service (no done pulse).
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int MAX   = 200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_len,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [WIDTH-1:0]          count_val,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [WIDTH-1:0] LEN_MAX  = WIDTH'(MAX - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic [WIDTH-1:0] len;

  // Terminal values above MAX-1 would walk the counter past its modulus.
  function automatic logic [WIDTH-1:0] clamp_len(input logic [WIDTH-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  // Index successor modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin pick: first set req bit at or after rr, wrapping. Scanning
  // from the far end lets the nearest candidate win by overwriting.
  always_comb begin
    pick = rr;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr) + i) % NREQ);
      if (req[cand]) pick = cand;
    end
  end

  // Control FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      count_val <= '0;
      owner     <= '0;
      rr        <= '0;
      len       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          if (|req) begin
            owner     <= pick;
            len       <= clamp_len(req_len[pick*WIDTH +: WIDTH]);
            count_val <= '0;
            grant     <= ONE_HOT0 << pick;
            busy      <= 1'b1;
            state     <= S_COUNT;
          end
        end
        S_COUNT: begin
`ifdef COUNTER_ARBITER_ABORT_EN
          if (!req[owner]) begin
            // Owner withdrew: release the counter silently.
            state     <= S_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            count_val <= '0;
            rr        <= next_idx(owner);
          end else if (count_val >= len) begin
            state     <= S_DONE;
            grant     <= '0;
            done      <= ONE_HOT0 << owner;
            count_val <= '0;
            rr        <= next_idx(owner);
          end else begin
            count_val <= count_val + 1'b1;
          end
`else
          // '>=' rather than '==' so a corrupted count can never run past len.
          if (count_val >= len) begin
            state     <= S_DONE;
            grant     <= '0;
            done      <= ONE_HOT0 << owner;
            count_val <= '0;
            rr        <= next_idx(owner);
          end else begin
            count_val <= count_val + 1'b1;
          end
`endif
        end
        S_DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: a transaction-level model predicts
// each service (owner, clamped length, start cycle) and a monitor checks the
// DUT outputs every cycle against the service timeline.
module tb_counter_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int MAX   = 200;
  localparam int IDX_W = 2;
`ifdef COUNTER_ARBITER_ABORT_EN
  localparam int ABORT = 1;
`else
  localparam int ABORT = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count_val;
  logic [IDX_W-1:0]      owner;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .count_val(count_val),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int owner;
    int len;
    int start;
  } svc_t;

  svc_t sb[$];
  int   cyc        = 0;
  int   next_free  = 0;
  int   rr_m       = 0;
  int   last_owner = 0;
  int   done_seen  = 0;
  int   max_cnt    = 0;
  int   done_log[$];

  // Service k is predicted at the edge where it is arbitrated; it occupies
  // edges start..start+len+2, so the next arbitration is at start+len+3.
  initial forever begin
    int pick, l, j;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb.delete();
      next_free  = 0;
      rr_m       = 0;
      last_owner = 0;
    end else begin
      cyc++;
`ifdef COUNTER_ARBITER_ABORT_EN
      if (sb.size() > 0) begin
        if (cyc > sb[0].start && cyc <= sb[0].start + sb[0].len + 1 &&
            !req[sb[0].owner]) begin
          sb.delete(0);
          next_free = cyc + 1;
        end
      end
`endif
      if (cyc >= next_free && req != 0) begin
        pick = -1;
        for (int i = 0; i < NREQ; i++) begin
          j = (rr_m + i) % NREQ;
          if (pick < 0 && req[j]) pick = j;
        end
        l = int'(req_len[pick*WIDTH +: WIDTH]);
        if (l > MAX - 1) l = MAX - 1;
        sb.push_back('{pick, l, cyc});
        last_owner = pick;
        rr_m       = (pick + 1) % NREQ;
        next_free  = cyc + l + 3;
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [NREQ-1:0] eg, ed;
    logic            eb;
    int              ec, s, L, o;
    bit              pop;
    @(negedge clk);
    if (rst_n) begin
      eg = '0; ed = '0; eb = 1'b0; ec = 0; pop = 1'b0;
      if (sb.size() > 0) begin
        s = sb[0].start; L = sb[0].len; o = sb[0].owner;
        if (cyc >= s && cyc <= s + L) begin
          eg = NREQ'(1) << o; ec = cyc - s; eb = 1'b1;
        end else if (cyc == s + L + 1) begin
          ed = NREQ'(1) << o; eb = 1'b1; pop = 1'b1;
        end
      end
      check($sformatf("outputs@%0d", cyc),
            32'({grant, done, busy, count_val, owner}),
            32'({eg, ed, eb, ec[WIDTH-1:0], last_owner[IDX_W-1:0]}));
      if (pop) void'(sb.pop_front());
      if (grant != 0 && int'(count_val) > max_cnt) max_cnt = int'(count_val);
      if (done != 0) begin
        done_seen++;
        for (int i = 0; i < NREQ; i++) if (done[i]) done_log.push_back(i);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_len(input int i, input int v);
    req_len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((req != 0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      req = req & ~done;
      n++;
    end
    if (req != 0 || sb.size() != 0) timeout(name);
  endtask

  task automatic wait_count(input string name, input int idx, input int val, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (grant[idx] && int'(count_val) == val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bit ok;
    int base, k;
    rst_n = 1'b0; req = '0; req_len = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({grant, done, busy, count_val, owner}), 32'd0);
    rst_n = 1'b1;

    // single request, len 5
    set_len(2, 5); req = 4'b0100;
    drain("single", 50);

    // all four with len 1, fresh rr pointer
    @(negedge clk); rst_n = 1'b0;
    #1 check("reset_again", 32'({grant, done, busy, count_val, owner}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    done_log.delete();
    req = 4'b1111;
    repeat (24) @(negedge clk);
    req = '0;
    drain("all_four", 50);
    if (done_log.size() < 5) timeout("rr_order");
    else for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(done_log[i]), 32'(exp_order[i]));

    // length clamp
    max_cnt = 0;
    set_len(0, 250); req = 4'b0001;
    drain("clamp", 300);
    check("clamp_max_count", 32'(max_cnt), 32'(MAX - 1));

    // length zero
    set_len(3, 0); req = 4'b1000;
    drain("len_zero", 20);

    // owner drops req mid-count
    set_len(1, 10); req = 4'b0010;
    wait_count("abort_wait", 1, 2, ok);
    base = done_seen;
    req = '0;
    repeat (20) @(negedge clk);
    check("abort_done_pulses", 32'(done_seen - base), 32'(1 - ABORT));

    // asynchronous reset mid-count
    set_len(2, 9); req = 4'b0100;
    wait_count("reset_wait", 2, 3, ok);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({grant, done, busy, count_val}), 32'd0);
    req = 4'b1010; set_len(1, 2); set_len(3, 2);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", 32'(grant), 32'(4'b0010));
    drain("post_reset", 50);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (done[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NREQ - 1);
        if ($urandom_range(0, 9) == 0) set_len(k, $urandom_range(190, 255));
        else set_len(k, $urandom_range(0, 12));
      end
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
    end
    drain("random", 3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
